// File: rtl/seg_display_reader.sv
// rtl/seg_display_reader.sv - passive decoder for a multiplexed active-low 7-segment display bus
// Rebuilds the shown BCD value one settled digit per anode dwell.
module seg_display_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_valid,
  output logic                    err,
  output logic [1:0]              err_digit
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [NUM_DIGITS-1:0] an_q, an_p, mask, mask_set;
  logic [6:0]            seg_q, seg_p;
  logic                  one_hot, stable, cap;
  logic [1:0]            sel;
  logic [5:0]            dec;

  // Returns {legal, blank, value}.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = {2'b10, 4'd0};
      7'b1001111: decode = {2'b10, 4'd1};
      7'b0010010: decode = {2'b10, 4'd2};
      7'b0000110: decode = {2'b10, 4'd3};
      7'b1001100: decode = {2'b10, 4'd4};
      7'b0100100: decode = {2'b10, 4'd5};
      7'b0100000: decode = {2'b10, 4'd6};
      7'b0001111: decode = {2'b10, 4'd7};
      7'b0000000: decode = {2'b10, 4'd8};
      7'b0000100: decode = {2'b10, 4'd9};
      7'b1111111: decode = {2'b11, 4'd0};
      default:    decode = {2'b00, 4'd0};
    endcase
  endfunction

  assign one_hot = $onehot(~an_q);
  assign stable  = (an_q == an_p) && (seg_q == seg_p);
  assign dec     = decode(seg_q);

  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) sel = 2'(i);
    end
  end

  assign mask_set = mask | (NUM_DIGITS'(1) << sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      an_q  <= '1;
      an_p  <= '1;
      seg_q <= 7'h7F;
      seg_p <= 7'h7F;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      an_q  <= an;
      an_p  <= an_q;
      seg_q <= seg;
      seg_p <= seg_q;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot) begin
          cnt_n   = CNT_W'(1);
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (!one_hot) begin
          state_n = IDLE;
        end else if (stable) begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt_n >= CNT_W'(SETTLE_CYCLES)) state_n = CAPTURE;
        end else begin
          cnt_n = CNT_W'(1);
        end
      end
      CAPTURE: begin
        // An anode that went away during the capture cycle yields no capture.
        cap     = one_hot;
        state_n = one_hot ? HOLD : IDLE;
      end
      HOLD: begin
        if (an_q != an_p) begin
          if (one_hot) begin
            cnt_n   = CNT_W'(1);
            state_n = SETTLE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_blank <= '1;
      mask        <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_digit   <= 2'd0;
    end else begin
      frame_valid <= 1'b0;
      err         <= 1'b0;
      if (cap) begin
        if (dec[5]) begin
          if (!dec[4]) digits[4*sel +: 4] <= dec[3:0];
          digit_blank[sel] <= dec[4];
          if (&mask_set) begin
            mask        <= '0;
            frame_valid <= 1'b1;
          end else begin
            mask <= mask_set;
          end
        end else begin
          err       <= 1'b1;
          err_digit <= sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_reader.sv
// tb/tb_seg_display_reader.sv - scoreboard bench for seg_display_reader
// Expected frames/errors are queued as scans are driven and popped on each DUT pulse.
module tb_seg_display_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_blank;
  logic        frame_valid;
  logic        err;
  logic [1:0]  err_digit;

  int n_tests = 0;
  int n_fail  = 0;
  int n_lat;

  logic [19:0] frame_q[$];
  logic [5:0]  err_q[$];
  logic [19:0] fexp;
  logic [5:0]  eexp;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000,
                         S9 = 7'b0000100, SB = 7'b1111111, SX = 7'b1111110;

  always #5 clk = ~clk;

  seg_display_reader #(.NUM_DIGITS(4), .SETTLE_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .digits(digits),
    .digit_blank(digit_blank), .frame_valid(frame_valid), .err(err), .err_digit(err_digit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  // Scan digits 3..0 with the given patterns.
  task automatic scan(input logic [6:0] s3, s2, s1, s0, input int n);
    dwell(4'b0111, s3, n);
    dwell(4'b1011, s2, n);
    dwell(4'b1101, s1, n);
    dwell(4'b1110, s0, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", digits, 16'h0);
    check("rst_blank", digit_blank, 4'hF);
    rst_n = 1'b1;
    dwell(4'hF, 7'h7F, 3);
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      if (frame_q.size() == 0) begin
        check("frame_unexpected", 1, 0);
      end else begin
        fexp = frame_q.pop_front();
        check("frame_digits", digits, fexp[19:4]);
        check("frame_blank", digit_blank, fexp[3:0]);
      end
    end
    if (rst_n && err) begin
      if (err_q.size() == 0) begin
        check("err_unexpected", 1, 0);
      end else begin
        eexp = err_q.pop_front();
        check("err_digit", err_digit, eexp[5:4]);
        check("err_held_nibble", digits[11:8], eexp[3:0]);
      end
    end
  end

  initial begin
    // Reset with random bus activity.
    for (int i = 0; i < 20; i++) begin
      an  = 4'($urandom);
      seg = 7'($urandom);
      @(negedge clk);
    end
    check("rst_digits", digits, 16'h0);
    check("rst_blank", digit_blank, 4'hF);
    check("rst_frame", frame_valid, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    dwell(4'hF, 7'h7F, 4);

    // First-capture latency: 18 edges after the bus change.
    an  = 4'b1110;
    seg = S1;
    n_lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) check("no_early_capture", digits, 16'h0);
      if (digits[3:0] == 4'd1) begin
        n_lat = i;
        break;
      end
    end
    check("latency", n_lat, 18);
    @(negedge clk);
    do_reset();

    // Static frames.
    frame_q.push_back({16'h1234, 4'h0});
    scan(S1, S2, S3, S4, 40);
    frame_q.push_back({16'h1234, 4'h0});
    scan(S1, S2, S3, S4, 40);
    dwell(4'hF, 7'h7F, 5);

    // Short dwells never settle.
    scan(S9, S9, S9, S9, 10);
    dwell(4'hF, 7'h7F, 5);
    check("glitch_digits", digits, 16'h1234);

    // Mid-dwell seg change: capture uses the final pattern.
    frame_q.push_back({16'h5678, 4'h0});
    dwell(4'b0111, S0, 8); dwell(4'b0111, S5, 32);
    dwell(4'b1011, S0, 8); dwell(4'b1011, S6, 32);
    dwell(4'b1101, S0, 8); dwell(4'b1101, S7, 32);
    dwell(4'b1110, S0, 8); dwell(4'b1110, S8, 32);
    dwell(4'hF, 7'h7F, 5);

    // Illegal digit 2, then the repair scan completes the frame at digit 2.
    err_q.push_back({2'd2, 4'h6});
    scan(S9, SX, S7, S6, 40);
    check("illegal_no_frame", frame_q.size(), 0);
    frame_q.push_back({16'h9876, 4'h0});
    scan(S9, S8, S7, S6, 40);
    dwell(4'hF, 7'h7F, 5);
    do_reset();

    // Blank digit 3.
    frame_q.push_back({16'h0059, 4'b1000});
    scan(SB, S0, S5, S9, 40);
    dwell(4'hF, 7'h7F, 5);

    // Two anodes low: no capture.
    dwell(4'b0011, S8, 100);
    dwell(4'hF, 7'h7F, 5);
    check("bad_anode_digits", digits, 16'h0059);

    // Three digits captured, reset mid-settle on the fourth.
    dwell(4'b0111, S1, 40);
    dwell(4'b1011, S2, 40);
    dwell(4'b1101, S3, 40);
    dwell(4'b1110, S4, 8);
    do_reset();
    frame_q.push_back({16'h4321, 4'h0});
    scan(S4, S3, S2, S1, 40);
    dwell(4'hF, 7'h7F, 10);

    check("frames_left", frame_q.size(), 0);
    check("errs_left", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/seg_display_reader.md
Name: seg_display_reader

Overview:
Snooper and decoder for the multiplexed 4-digit, active-low 7-segment display bus driven by the stopwatch/timer. It watches the anode scan and segment lines, waits for each lit digit to settle, and converts the segment pattern back to BCD. It reassembles the 4-digit value shown on the display, for self-test and testbench checking. It is passive: it only observes the bus.

Parameters:
NUM_DIGITS, 4, number of anode lines and digits per frame (fixed at 4 for this revision).
SETTLE_CYCLES, 16, consecutive identical samples required before a digit is captured (min 2).
CNT_W, 8, settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
an  in  4  anode enables, active-low; an[i]=0 selects digit i (digit 0 = rightmost).
seg  in  7  segments, active-low; seg[6]=a, seg[5]=b … seg[0]=g.
digits  out  16  captured BCD; digit i in [4i+3:4i].
digit_blank  out  4  1 = last valid capture of digit i was blank (seg=7'b1111111).
frame_valid  out  1  1-cycle pulse: all 4 digits captured since the last pulse.
err  out  1  1-cycle pulse: a settled pattern was not a legal code.
err_digit  out  2  index of the digit that caused the last err; held until the next err.

Behaviour:
- Reset (async, rst_n=0): digits=0, digit_blank=4'hF, frame_valid=0, err=0, err_digit=0, capture mask=0, counter=0, state=IDLE. Registered input samples clear to an_q=4'hF and seg_q=7'h7F.
- an and seg are registered every clk (an_q, seg_q). All decisions use the registered samples. "Stable" means the current sample equals the previous sample.
- Legal codes (seg -> value): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111->blank. Any other pattern is illegal.
- FSM:
  - IDLE: wait until an_q is one-hot-low (exactly one bit 0). Then load counter=1 and go to SETTLE.
  - SETTLE: if the sample is stable, counter++. If it changes but an_q is still one-hot-low, counter=1 and stay. If an_q is not one-hot-low, go to IDLE. When counter reaches SETTLE_CYCLES, go to CAPTURE.
  - CAPTURE (1 cycle), decoding the selected digit index k:
    - Legal digit: digits[k] and digit_blank[k]=0 update on this edge; mask[k] is set.
    - Blank: digits[k] holds its value; digit_blank[k]=1; mask[k] is set.
    - Illegal: err=1, err_digit=k; digits, digit_blank and mask are unchanged.
    - Next state is HOLD.
  - HOLD: stay while an_q is unchanged; seg changes are ignored, so there is one capture per anode dwell. When an_q changes to another one-hot-low value, counter=1 and go to SETTLE. Any other an_q change goes to IDLE.
- Frame: when the mask becomes 4'hF (the update that sets the last bit), frame_valid pulses in the same cycle the final digit is visible on digits, and the mask clears to 0. Recapturing an already-masked digit overwrites the data and leaves the mask unchanged.
- Latency: the first capture lands on the clk edge 1 + SETTLE_CYCLES + 1 edges after the an/seg change (input register, settle, capture).
- Multiple anodes low, or all high: treated as not one-hot; no capture, no err.
- Reset mid-SETTLE or mid-frame: everything returns to reset values immediately; a partial mask is lost.
- err and frame_valid may pulse in the same cycle only if they concern different events. This cannot occur, since there is one capture per cycle. err never sets a mask bit.

Test Plan:
- Reset check: hold rst_n=0 with random bus activity -> digits=0, digit_blank=F, frame_valid=0, err=0. Release -> no output change until a full settle.
- Static frame: scan 1,2,3,4 on digits 3..0 (seg 1001111, 0010010, 0000110, 1001100), 40 cycles per digit -> one frame_valid pulse with digits=16'h1234; repeating the scan gives a pulse every 160 cycles.
- Glitch rejection: dwell only 10 cycles with SETTLE_CYCLES=16 -> no capture and no frame_valid. Toggle seg at cycle 8 of a 40-cycle dwell -> capture once at ~cycle 25 with the final pattern.
- Illegal pattern: digit 2 shows 7'b1111110 -> err pulse once, err_digit=2, digits[11:8] unchanged, no frame_valid that scan. The next scan with the legal code completes the frame.
- Blank digit: digit 3 is blank, the others show 0,5,9 -> frame_valid, digit_blank=4'b1000, digits[11:0]=12'h059.
- Bad anode and reset: an=4'b0011 for 100 cycles -> no capture. Assert rst_n low mid-SETTLE after 3 digits are captured -> mask cleared; the next full scan is needed before frame_valid.
